ps2_key_encoder: RTL and testbench
==================================

PS2_KEY_ENCODER -- requirements
Module: ps2_key_encoder

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 20'd600000, giving the maximum idle gap between bytes of one sequence, in clk_sys cycles.
REQ-002 clk_sys  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 RESET_N  input  1  reset; one clock, asynchronous, active-low.
REQ-004 byte_valid  input  1  high for one cycle per received scan-code byte.
REQ-005 byte_in  input  8  scan-code byte, sampled when byte_valid=1.
REQ-006 ps2_key  output  65  key event word: [64] toggle, [63:0] event bytes.
REQ-007 key_strobe  output  1  one-cycle pulse when ps2_key changes.
REQ-008 seq_error  output  1  one-cycle pulse on an aborted sequence.

Function
REQ-009 The block SHALL accept one byte on every cycle with byte_valid=1, with no back-pressure.
REQ-010 The block SHALL shift each accepted byte into an internal 64-bit sequence register: the newest byte at [7:0], older bytes moved up 8 bits, unused bytes zero.
REQ-011 On completion of a sequence, the block SHALL copy the register to ps2_key[63:0], invert ps2_key[64] and pulse key_strobe in the cycle after the final byte is accepted (latency 1).
REQ-012 After emission, the sequence register SHALL clear to zero and the FSM SHALL return to IDLE.
REQ-013 FSM states SHALL be: IDLE, EXT, REL, EXT_REL, PRN_MK, PRN_RL, PAUSE.
REQ-014 IDLE handling:
- E0 -> EXT; F0 -> REL; E1 -> PAUSE with count=7.
- 00, AA, EE, FA, FC, FE, FF -> discarded silently; register unchanged; stay IDLE.
- Any other byte -> emit a 1-byte event.
REQ-015 EXT handling: F0 -> EXT_REL; 12 -> PRN_MK with count=2; other -> emit a 2-byte event (E0 xx).
REQ-016 REL handling: any byte -> emit a 2-byte event (F0 xx).
REQ-017 EXT_REL handling: 7C -> PRN_RL with count=3; other -> emit a 3-byte event (E0 F0 xx).
REQ-018 PRN_MK SHALL expect exactly E0 then 7C and then emit the 4-byte event E0 12 E0 7C.
REQ-019 PRN_RL SHALL expect exactly E0, F0, 12 and then emit the 6-byte event E0 F0 7C E0 F0 12.
REQ-020 A mismatching byte in PRN_MK or PRN_RL SHALL discard that byte and the register, pulse seq_error next cycle, leave ps2_key unchanged and go to IDLE.
REQ-021 PAUSE SHALL accept the next 7 bytes with any values, decrementing count, and emit the 8-byte event when count reaches 0 (E1 14 77 E1 F0 14 F0 77 appears unchanged as the 64-bit value).
REQ-022 Timeout counter:
- cleared on every accepted byte and in IDLE;
- increments otherwise;
- at TIMEOUT_CYCLES outside IDLE, the FSM SHALL discard the register, pulse seq_error and go to IDLE.
REQ-023 If byte_valid=1 in the cycle the timeout is reached, the byte SHALL take priority: the counter clears and the byte is processed normally.
REQ-024 The counter SHALL saturate and never wrap.
REQ-025 key_strobe and seq_error SHALL never pulse in the same cycle.
REQ-026 Back-to-back sequences SHALL be supported: a byte accepted in the emission cycle starts the next sequence from IDLE.

Reset
REQ-027 While RESET_N=0, the block SHALL hold: ps2_key=65'h0, key_strobe=0, seq_error=0, FSM=IDLE, register=0, count=0, timeout counter=0.
REQ-028 Deassertion of RESET_N in the middle of a sequence SHALL leave the FSM in IDLE with no event emitted.

Verification
REQ-029 Byte 1C, then later 1C again -> ps2_key = {1'b1, 64'h1C}, then {1'b0, 64'h1C}, each with one key_strobe.
REQ-030 Bytes E0 F0 75 on consecutive cycles -> one cycle after 75: ps2_key[63:0] = 64'hE0F075, [64] toggled, one strobe.
REQ-031 Bytes E0 12 E0 7C -> ps2_key[63:0] = 64'hE012E07C; bytes E0 12 E0 7D -> no event, one seq_error pulse, FSM in IDLE.
REQ-032 The 8-byte PAUSE sequence -> ps2_key[63:0] = 64'hE11477E1F014F077, exactly one strobe.
REQ-033 Byte E0, then idle for TIMEOUT_CYCLES -> seq_error pulse, no event; then byte 29 -> 64'h29. A byte arriving on the timeout cycle -> no seq_error.
REQ-034 Bytes FA and AA -> no strobe; RESET_N low after F0 -> all outputs 0; then byte 14 -> 64'h14.

Source files
------------

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: assembles PS/2 scan-code bytes into complete key-event words.
// Revision 1.0
`default_nettype none

module ps2_key_encoder #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd600000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [64:0] ps2_key,
    output logic        key_strobe,
    output logic        seq_error
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_REL   = 8'hF0;
    localparam logic [7:0] CODE_PAUSE = 8'hE1;
    localparam logic [7:0] CODE_PRN1  = 8'h12;
    localparam logic [7:0] CODE_PRN2  = 8'h7C;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        REL     = 3'd2,
        EXT_REL = 3'd3,
        PRN_MK  = 3'd4,
        PRN_RL  = 3'd5,
        PAUSE   = 3'd6
    } state_t;

    state_t      state, next_state;
    logic [63:0] seq_reg, next_seq, shifted;
    logic [2:0]  count, next_count;
    logic [19:0] tmo_cnt;
    logic        emit, abort;
    logic [7:0]  prn_expect;

    assign shifted = (seq_reg << 8) | {56'd0, byte_in};

    always_comb begin
        next_state = state;
        next_seq   = seq_reg;
        next_count = count;
        emit       = 1'b0;
        abort      = 1'b0;
        prn_expect = 8'h00;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    case (byte_in)
                        CODE_EXT:   begin next_state = EXT; next_seq = shifted; end
                        CODE_REL:   begin next_state = REL; next_seq = shifted; end
                        CODE_PAUSE: begin
                            next_state = PAUSE;
                            next_seq   = shifted;
                            next_count = 3'd7;
                        end
                        // Controller replies and idle fill are not key events.
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
                        default: emit = 1'b1;
                    endcase
                end
                EXT: begin
                    if (byte_in == CODE_REL) begin
                        next_state = EXT_REL;
                        next_seq   = shifted;
                    end else if (byte_in == CODE_PRN1) begin
                        next_state = PRN_MK;
                        next_seq   = shifted;
                        next_count = 3'd2;
                    end else begin
                        emit = 1'b1;
                    end
                end
                REL: emit = 1'b1;
                EXT_REL: begin
                    if (byte_in == CODE_PRN2) begin
                        next_state = PRN_RL;
                        next_seq   = shifted;
                        next_count = 3'd3;
                    end else begin
                        emit = 1'b1;
                    end
                end
                PRN_MK, PRN_RL: begin
                    // count selects which byte of the fixed tail is due next
                    if (state == PRN_MK)
                        prn_expect = (count == 3'd2) ? CODE_EXT : CODE_PRN2;
                    else
                        prn_expect = (count == 3'd3) ? CODE_EXT :
                                     (count == 3'd2) ? CODE_REL : CODE_PRN1;
                    if (byte_in != prn_expect) begin
                        abort = 1'b1;
                    end else if (count == 3'd1) begin
                        emit = 1'b1;
                    end else begin
                        next_seq   = shifted;
                        next_count = count - 3'd1;
                    end
                end
                PAUSE: begin
                    if (count == 3'd1) begin
                        emit = 1'b1;
                    end else begin
                        next_seq   = shifted;
                        next_count = count - 3'd1;
                    end
                end
                default: abort = 1'b1;
            endcase
        end else if (state != IDLE && tmo_cnt >= TIMEOUT_CYCLES) begin
            abort = 1'b1;
        end
        if (emit || abort) begin
            next_state = IDLE;
            next_seq   = 64'd0;
            next_count = 3'd0;
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            seq_reg    <= 64'd0;
            count      <= 3'd0;
            tmo_cnt    <= 20'd0;
            ps2_key    <= 65'd0;
            key_strobe <= 1'b0;
            seq_error  <= 1'b0;
        end else begin
            state      <= next_state;
            seq_reg    <= next_seq;
            count      <= next_count;
            key_strobe <= emit;
            seq_error  <= abort;
            if (emit)
                ps2_key <= {~ps2_key[64], shifted};
            if (byte_valid || state == IDLE)
                tmo_cnt <= 20'd0;
            else if (tmo_cnt < TIMEOUT_CYCLES)
                tmo_cnt <= tmo_cnt + 20'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed stimulus with an event scoreboard for ps2_key_encoder.
// Revision 1.0
`default_nettype none

module tb_ps2_key_encoder;

    localparam int T = 20;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic [64:0] ps2_key;
    logic        key_strobe;
    logic        seq_error;

    ps2_key_encoder #(.TIMEOUT_CYCLES(20'(T))) dut (
        .clk_sys    (clk_sys),
        .RESET_N    (RESET_N),
        .byte_valid (byte_valid),
        .byte_in    (byte_in),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe),
        .seq_error  (seq_error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic        is_err;
        logic [64:0] key;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [64:0] exp_key = 65'd0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] want);
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    always @(negedge clk_sys) begin
        if (RESET_N && (key_strobe || seq_error)) begin
            chk("strobe_and_error_exclusive", 65'({key_strobe, seq_error}), 65'(key_strobe ? 2'b10 : 2'b01));
            if (q.size() == 0) begin
                chk("unexpected_output", 65'({key_strobe, seq_error}), 65'd0);
            end else begin
                e = q.pop_front();
                chk("event_kind", 65'(seq_error), 65'(e.is_err));
                chk(e.is_err ? "key_held_on_error" : "event_key", ps2_key, e.key);
            end
        end
    end

    task automatic put(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk_sys);
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic exp_evt(input logic [63:0] data);
        exp_key = {~exp_key[64], data};
        q.push_back({1'b0, exp_key});
    endtask

    task automatic exp_err();
        q.push_back({1'b1, exp_key});
    endtask

    task automatic drained(input string tag);
        idle(3);
        chk(tag, 65'(q.size()), 65'd0);
    endtask

    initial begin
        idle(2);
        chk("reset_key", ps2_key, 65'd0);
        chk("reset_strobe", 65'(key_strobe), 65'd0);
        chk("reset_error", 65'(seq_error), 65'd0);
        RESET_N = 1'b1;
        idle(2);

        exp_evt(64'h1C); put(8'h1C); idle(4);
        chk("toggle_first", 65'(ps2_key[64]), 65'd1);
        exp_evt(64'h1C); put(8'h1C);
        drained("make_1c_twice");
        chk("toggle_second", 65'(ps2_key[64]), 65'd0);

        put(8'hE0); put(8'hF0); exp_evt(64'hE0F075); put(8'h75);
        drained("ext_release");

        put(8'hE0); put(8'h12); put(8'hE0); exp_evt(64'hE012E07C); put(8'h7C);
        put(8'hE0); put(8'h12); put(8'hE0); exp_err(); put(8'h7D);
        drained("print_make_and_abort");

        put(8'hE0); exp_evt(64'hE075); put(8'h75);
        put(8'hF0); exp_evt(64'hF01C); put(8'h1C);
        drained("two_byte_events");

        put(8'hE0); put(8'hF0); put(8'h7C); put(8'hE0); put(8'hF0);
        exp_evt(64'hE0F07CE0F012); put(8'h12);
        put(8'hE0); put(8'hF0); put(8'h7C); put(8'hE0); exp_err(); put(8'h00);
        drained("print_release_and_abort");

        put(8'hE1); put(8'h14); put(8'h77); put(8'hE1);
        put(8'hF0); put(8'h14); put(8'hF0);
        exp_evt(64'hE11477E1F014F077); put(8'h77);
        drained("pause");

        exp_evt(64'h1C); put(8'h1C); exp_evt(64'h32); put(8'h32);
        put(8'hE0); put(8'hF0); exp_evt(64'hE0F075); put(8'h75);
        exp_evt(64'h1C); put(8'h1C);
        drained("back_to_back");

        put(8'hE0); idle(T + 1); exp_err();
        exp_evt(64'h29); put(8'h29);
        drained("timeout_abort");

        put(8'hE0); idle(T); exp_evt(64'hE075); put(8'h75);
        drained("byte_on_timeout_cycle");

        put(8'hFA); put(8'hAA); exp_evt(64'h1C); put(8'h1C);
        drained("ignored_bytes");

        put(8'hF0);
        RESET_N = 1'b0;
        #1;
        chk("midseq_reset_key", ps2_key, 65'd0);
        chk("midseq_reset_flags", 65'({key_strobe, seq_error}), 65'd0);
        exp_key = 65'd0;
        idle(2);
        RESET_N = 1'b1;
        idle(1);
        exp_evt(64'h14); put(8'h14);
        drained("after_reset");
        chk("after_reset_key", ps2_key, {1'b1, 64'h14});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
